// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment bit map, scan FSM encoding and hex glyph table
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Glyphs packed as {g,f,e,d,c,b,a}; letters are A, b, C, d, E, F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex digit plus decimal point to segment pattern
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph       = HEX_SEG[hex];
    seg         = '0;
    seg[SEG_A]  = glyph[0];
    seg[SEG_B]  = glyph[1];
    seg[SEG_C]  = glyph[2];
    seg[SEG_D]  = glyph[3];
    seg[SEG_E]  = glyph[4];
    seg[SEG_F]  = glyph[5];
    seg[SEG_G]  = glyph[6];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with pending/active digit banks
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_idx,
  input  logic [3:0]            in_data,
  input  logic                  in_dp,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done,
  output logic                  wr_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX  = DW'(NUM_DIGITS - 1);
  localparam logic [3:0]    NUM_DIG4 = 4'(NUM_DIGITS);

  scan_state_t   state, nstate;
  logic [DW-1:0] digit, ndigit;
  logic [CW-1:0] cnt, ncnt;

  logic [3:0] pend_data   [NUM_DIGITS];
  logic       pend_dp     [NUM_DIGITS];
  logic [3:0] active_data [NUM_DIGITS];
  logic       active_dp   [NUM_DIGITS];
  logic [3:0] pnext_data  [NUM_DIGITS];
  logic       pnext_dp    [NUM_DIGITS];

  logic       wr_fire, wr_ok, wr_bad;
  logic       commit_now, next_commit;
  logic [3:0] dec_hex;
  logic       dec_dp;
  logic [7:0] dec_seg;

  assign wr_fire    = in_valid && in_ready;
  assign wr_ok      = wr_fire && ({1'b0, in_idx} < NUM_DIG4);
  assign wr_bad     = wr_fire && ({1'b0, in_idx} >= NUM_DIG4);
  assign commit_now = en && (state == ST_SHOW) && (digit == DIG_MAX) && (cnt == CNT_MAX);

  // Pending bank as it will be after this edge; also the commit source so a
  // write landing on the commit cycle is not lost for a frame.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pnext_data[i] = pend_data[i];
      pnext_dp[i]   = pend_dp[i];
      if (wr_ok && (in_idx == 3'(i))) begin
        pnext_data[i] = in_data;
        pnext_dp[i]   = in_dp;
      end
    end
  end

  always_comb begin
    nstate = ST_GUARD;
    ndigit = '0;
    ncnt   = '0;
    if (en) begin
      if (cnt == CNT_MAX) begin
        ncnt   = '0;
        ndigit = (digit == DIG_MAX) ? '0 : digit + 1'b1;
      end else begin
        ncnt   = cnt + 1'b1;
        ndigit = digit;
      end
      nstate = (int'(ncnt) < BLANK_CYCLES) ? ST_GUARD : ST_SHOW;
    end
  end

  assign next_commit = en && (nstate == ST_SHOW) && (ndigit == DIG_MAX) && (ncnt == CNT_MAX);

  // Outputs are registered from the next state, so with no guard slot the
  // first digit of a frame must already see the freshly committed value.
  always_comb begin
    dec_hex = active_data[ndigit];
    dec_dp  = active_dp[ndigit];
    if (commit_now) begin
      dec_hex = pnext_data[ndigit];
      dec_dp  = pnext_dp[ndigit];
    end
  end

  seg_hex_decoder u_dec (
    .hex (dec_hex),
    .dp  (dec_dp),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_GUARD;
      digit      <= '0;
      cnt        <= '0;
      an         <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
      wr_err     <= 1'b0;
      in_ready   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_data[i]   <= '0;
        pend_dp[i]     <= 1'b0;
        active_data[i] <= '0;
        active_dp[i]   <= 1'b0;
      end
    end else begin
      in_ready   <= 1'b1;
      wr_err     <= wr_bad;
      state      <= nstate;
      digit      <= ndigit;
      cnt        <= ncnt;
      frame_done <= next_commit;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_data[i] <= pnext_data[i];
        pend_dp[i]   <= pnext_dp[i];
        if (commit_now) begin
          active_data[i] <= pnext_data[i];
          active_dp[i]   <= pnext_dp[i];
        end
      end
      if (nstate == ST_SHOW) begin
        an  <= NUM_DIGITS'(1) << ndigit;
        seg <= dec_seg;
      end else begin
        an  <= '0;
        seg <= '0;
      end
    end
  end

endmodule
